// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: single-outstanding sequential prefetcher feeding a
// small {pc, inst} queue towards ID, with redirect flush and stale-response drop.
module ifu_prefetch #(
    parameter int unsigned                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]        RESET_PC   = 32'h8000_0000,
    parameter int unsigned                  FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fetch_enable_i,
    input  logic                    redirect_valid_i,
    input  logic [DATA_WIDTH-1:0]   redirect_pc_i,
    output logic                    imem_req_valid_o,
    input  logic                    imem_req_ready_i,
    output logic [DATA_WIDTH-1:0]   imem_req_addr_o,
    input  logic                    imem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]   imem_resp_data_i,
    output logic                    if_to_id_valid_o,
    input  logic                    id_to_if_ready_i,
    output logic [2*DATA_WIDTH-1:0] if_to_id_bus_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                    drop_q, drop_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic credit;
    logic start;

    always_comb begin
        push   = (state_q == S_WAIT) && imem_resp_valid_i && !drop_q && !redirect_valid_i;
        pop    = (count_q != '0) && id_to_if_ready_i;
        // The slot for a response pushed this very cycle must be reserved before
        // a follow-on request is issued, otherwise a stalled ID could overflow us.
        credit = redirect_valid_i || ((count_q + CW'(push)) < DEPTH_C);
        start  = fetch_enable_i && credit;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    addr_d  = redirect_valid_i ? redirect_pc_i : fetch_pc_q;
                end
            end
            S_REQ: begin
                if (imem_req_ready_i) begin
                    state_d  = S_WAIT;
                    req_pc_d = addr_q;
                    // A stale request (redirected while stalled) must not advance the pc.
                    if (!drop_q) begin
                        fetch_pc_d = addr_q + DATA_WIDTH'(4);
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid_i) begin
                    drop_d = 1'b0;
                    if (start) begin
                        state_d = S_REQ;
                        addr_d  = redirect_valid_i ? redirect_pc_i : fetch_pc_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            if ((state_q == S_REQ) || ((state_q == S_WAIT) && !imem_resp_valid_i)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (redirect_valid_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries data only; validity lives entirely in count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_pc_q, imem_resp_data_i};
        end
    end

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_req_addr_o  = addr_q;
    assign if_to_id_valid_o = (count_q != '0);
    assign if_to_id_bus_o   = mem_q[rd_ptr_q];

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction fetch unit with a decoupled, variable-latency instruction-memory port and a prefetch queue of `{pc, inst}` entries. It sits between the instruction memory and the ID stage. It fetches sequentially (pc+4) ahead of decode, delivers instructions to ID through a valid/ready handshake, and on a redirect from ID flushes the queue and discards stale in-flight responses.

## Interface
- `DATA_WIDTH`, 32: width of pc and instruction words.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fetch_enable` in 1: when 0, no new memory request is issued. An in-flight request and its response complete normally.
- `redirect_valid` in 1: ID supplies a new pc (dnpc). Always accepted.
- `redirect_pc` in DATA_WIDTH: redirect target.
- `imem_req_valid` out 1: memory request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out DATA_WIDTH: request address.
- `imem_resp_valid` in 1: response data valid. Always accepted; never back-pressured.
- `imem_resp_data` in DATA_WIDTH: instruction word.
- `if_to_id_valid` out 1: queue head valid.
- `id_to_if_ready` in 1: ID accepts head.
- `if_to_id_bus` out 2*DATA_WIDTH: `{pc, inst}` of queue head.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: `imem_req_valid`=1, waiting for ready.
  - WAIT: request accepted, waiting for response.
- At most one request is outstanding.
- IDLE→REQ when all of the following hold:
  - `fetch_enable`=1
  - occupancy < FIFO_DEPTH (credit check; guarantees a response always has a slot)
  - not in reset
- REQ→WAIT on `imem_req_valid && imem_req_ready`.
- WAIT→IDLE on `imem_resp_valid`.
- A zero-latency return from WAIT→REQ in the response cycle is permitted if the IDLE conditions already hold.
- `fetch_pc` register:
  - Reset: RESET_PC.
  - `imem_req_addr` = `fetch_pc`, held stable while in REQ.
  - On request acceptance: `fetch_pc` <= `fetch_pc`+4 (mod 2^DATA_WIDTH, wraps). `req_pc` <= `fetch_pc`.
- On a non-dropped response: push `{req_pc, imem_resp_data}` into the queue.
- Dequeue on `if_to_id_valid && id_to_if_ready`. `if_to_id_valid` = queue not empty.
- Redirect (`redirect_valid`=1), effective at the edge:
  - Queue emptied. `fetch_pc` <= `redirect_pc`; low bits are not altered.
  - If in WAIT, or in REQ and accepted this cycle: set `drop` so the next response is discarded (not pushed).
  - If in REQ and not accepted: the request stays valid with its old address until accepted (no withdrawal). Its response is dropped. The redirect address is requested afterwards.
  - A redirect in the same cycle as a response: that response is dropped.
  - A redirect in the same cycle as a dequeue: the dequeue counts as done (ID consumed the old head). The flush still applies.
  - A redirect in IDLE: request for `redirect_pc` in the next cycle, subject to `fetch_enable`/credit.
- `drop` clears on the dropped response. A second redirect while `drop`=1 keeps `drop`=1; only one response is outstanding.
- Simultaneous push and pop with the queue full: the credit rule makes this impossible. Simultaneous push and pop at any legal occupancy: occupancy unchanged.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A memory response arriving during or just after reset is ignored (state IDLE).

## Timing
- Reset values:
  - `imem_req_valid`=0, `if_to_id_valid`=0, `imem_req_addr`=RESET_PC
  - `if_to_id_bus`=don't care
  - state=IDLE, occupancy=0, `drop`=0
- `imem_req_valid` is registered. First assertion is in the first cycle after `rst` deasserts, with addr RESET_PC.
- Zero-wait memory: request accepted cycle N, response N+1, `if_to_id_valid` high N+2.
- Outputs to ID come from queue registers; there is no combinational path from `imem_resp_*` to `if_to_id_*`.
- Throughput with one-cycle-response memory: one instruction every 2 cycles (single outstanding request).
- Redirect at edge N: queue empty and `if_to_id_valid`=0 in cycle N+1. The earliest redirect-target request is in cycle N+1 (from IDLE).

## Test plan
- Reset release, memory always ready, 1-cycle response, ID always ready → requests 0x80000000, 0x80000004, 0x80000008…; bus delivers matching `{pc,inst}` in order.
- ID stalls (`id_to_if_ready`=0) with FIFO_DEPTH=4 → exactly 4 entries buffered, no 5th request issued. Release → 4 entries drain in order, fetching resumes.
- Redirect to 0x80001000 while in WAIT → old response not delivered; next bus pc=0x80001000.
- Redirect while REQ is stalled (`imem_req_ready`=0 for 3 cycles) → address stays stable until accepted, its response dropped, next request addr 0x80001000.
- `fetch_enable`=0 for 5 cycles mid-stream → no new request, the outstanding one completes, sequence resumes with no pc skipped.
- Assert `rst` during WAIT, response arrives during reset → nothing enqueued; after release the first request is again RESET_PC.
